// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and external hold.
// A load-use hazard inserts one bubble and stalls IF/ID. A saturating counter tallies those bubbles.
module id_ex_stage #(
    parameter int DATA_W = 10,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rd_sel1,
    input  logic [REG_W-1:0]  id_rd_sel2,
    input  logic [REG_W-1:0]  id_write_sel,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [DATA_W-1:0] id_rd_data1,
    input  logic [DATA_W-1:0] id_rd_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_imm_sel,
    input  logic              id_reg_write_en,
    input  logic              id_MemtoReg,
    input  logic              id_mem_write_en,
    input  logic [3:0]        id_alu_op,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  rd_sel1_in,
    output logic [REG_W-1:0]  rd_sel2_in,
    output logic [REG_W-1:0]  write_sel_EX,
    output logic [DATA_W-1:0] ex_rd_data1,
    output logic [DATA_W-1:0] ex_rd_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              imm_sel,
    output logic              reg_write_en_EX,
    output logic              MemtoReg_EX,
    output logic              mem_write_en_EX,
    output logic [3:0]        alu_op_EX,
    output logic              stall_IF_ID,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] imm;
        logic              imm_sel;
        logic              rwe;
        logic              m2r;
        logic              mwe;
        logic [3:0]        alu_op;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    always_comb begin
        // The immediate replaces rs2, so an rs2 match is ignored when imm_sel is set.
        hazard = ex_q.valid & ex_q.rwe & ex_q.m2r & id_valid &
                 ((id_uses_rs1 & (id_rd_sel1 == ex_q.rd)) |
                  (id_uses_rs2 & ~id_imm_sel & (id_rd_sel2 == ex_q.rd)));
        stall_IF_ID = ext_stall | (hazard & ~flush);

        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (ext_stall) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d  = '0;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (!id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid   = 1'b1;
            ex_d.rs1     = id_rd_sel1;
            ex_d.rs2     = id_rd_sel2;
            ex_d.rd      = id_write_sel;
            ex_d.d1      = id_rd_data1;
            ex_d.d2      = id_rd_data2;
            ex_d.imm     = id_imm;
            ex_d.imm_sel = id_imm_sel;
            ex_d.rwe     = id_reg_write_en;
            ex_d.m2r     = id_MemtoReg;
            ex_d.mwe     = id_mem_write_en;
            ex_d.alu_op  = id_alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid        = ex_q.valid;
    assign rd_sel1_in      = ex_q.rs1;
    assign rd_sel2_in      = ex_q.rs2;
    assign write_sel_EX    = ex_q.rd;
    assign ex_rd_data1     = ex_q.d1;
    assign ex_rd_data2     = ex_q.d2;
    assign ex_imm          = ex_q.imm;
    assign imm_sel         = ex_q.imm_sel;
    assign reg_write_en_EX = ex_q.rwe;
    assign MemtoReg_EX     = ex_q.m2r;
    assign mem_write_en_EX = ex_q.mwe;
    assign alu_op_EX       = ex_q.alu_op;
    assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use, priority, saturation.
module tb_id_ex_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rd_sel1, id_rd_sel2, id_write_sel;
    logic       id_uses_rs1, id_uses_rs2;
    logic [9:0] id_rd_data1, id_rd_data2, id_imm;
    logic       id_imm_sel, id_reg_write_en, id_MemtoReg, id_mem_write_en;
    logic [3:0] id_alu_op;
    logic       flush, ext_stall;
    logic       ex_valid;
    logic [2:0] rd_sel1_in, rd_sel2_in, write_sel_EX;
    logic [9:0] ex_rd_data1, ex_rd_data2, ex_imm;
    logic       imm_sel, reg_write_en_EX, MemtoReg_EX, mem_write_en_EX;
    logic [3:0] alu_op_EX;
    logic       stall_IF_ID;
    logic [7:0] bubble_cnt;

    int passed = 0;
    int total  = 0;

    id_ex_stage #(.DATA_W(10), .REG_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rd_sel1(id_rd_sel1), .id_rd_sel2(id_rd_sel2), .id_write_sel(id_write_sel),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2), .id_imm(id_imm),
        .id_imm_sel(id_imm_sel), .id_reg_write_en(id_reg_write_en),
        .id_MemtoReg(id_MemtoReg), .id_mem_write_en(id_mem_write_en),
        .id_alu_op(id_alu_op), .flush(flush), .ext_stall(ext_stall),
        .ex_valid(ex_valid), .rd_sel1_in(rd_sel1_in), .rd_sel2_in(rd_sel2_in),
        .write_sel_EX(write_sel_EX), .ex_rd_data1(ex_rd_data1), .ex_rd_data2(ex_rd_data2),
        .ex_imm(ex_imm), .imm_sel(imm_sel), .reg_write_en_EX(reg_write_en_EX),
        .MemtoReg_EX(MemtoReg_EX), .mem_write_en_EX(mem_write_en_EX),
        .alu_op_EX(alu_op_EX), .stall_IF_ID(stall_IF_ID), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rd_sel1 = 0; id_rd_sel2 = 0; id_write_sel = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_rd_data1 = 0; id_rd_data2 = 0; id_imm = 0;
        id_imm_sel = 0; id_reg_write_en = 0; id_MemtoReg = 0; id_mem_write_en = 0; id_alu_op = 0;
    endtask

    // Load writing wsel, captured into EX on the next edge.
    task automatic load_into_ex(input logic [2:0] wsel, input logic [9:0] d1);
        clear_id();
        id_valid = 1; id_write_sel = wsel; id_reg_write_en = 1; id_MemtoReg = 1;
        id_rd_data1 = d1; id_alu_op = 4'h1;
        tick();
    endtask

    task automatic dep_rs1(input logic [2:0] src);
        clear_id();
        id_valid = 1; id_rd_sel1 = src; id_uses_rs1 = 1; id_write_sel = 3'b011;
        id_reg_write_en = 1; id_rd_data1 = 10'h0AB; id_alu_op = 4'h5;
    endtask

    initial begin
        flush = 0; ext_stall = 0;
        clear_id();
        // Reset with every id_* field nonzero
        rst = 1; id_valid = 1; id_rd_sel1 = 3'h7; id_rd_sel2 = 3'h6; id_write_sel = 3'h5;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_rd_data1 = 10'h3FF; id_rd_data2 = 10'h155;
        id_imm = 10'h2AA; id_imm_sel = 1; id_reg_write_en = 1; id_MemtoReg = 1;
        id_mem_write_en = 1; id_alu_op = 4'hF;
        tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_wsel", write_sel_EX, 0);
        chk("rst_d1", ex_rd_data1, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_ctrl", {imm_sel, reg_write_en_EX, MemtoReg_EX, mem_write_en_EX}, 0);
        chk("rst_alu", alu_op_EX, 0);
        chk("rst_stall", stall_IF_ID, 0);
        chk("rst_cnt", bubble_cnt, 0);
        rst = 0;

        // Pass-through
        clear_id();
        id_valid = 1; id_write_sel = 3'b101; id_rd_data1 = 10'h2A5; id_alu_op = 4'h3;
        id_reg_write_en = 1; id_rd_data2 = 10'h1C3;
        #1 chk("pt_stall", stall_IF_ID, 0);
        tick();
        chk("pt_valid", ex_valid, 1);
        chk("pt_wsel", write_sel_EX, 3'b101);
        chk("pt_d1", ex_rd_data1, 10'h2A5);
        chk("pt_d2", ex_rd_data2, 10'h1C3);
        chk("pt_alu", alu_op_EX, 4'h3);
        chk("pt_rwe", reg_write_en_EX, 1);

        // Load-use on rs1
        load_into_ex(3'b010, 10'h111);
        chk("lu_load_m2r", MemtoReg_EX, 1);
        dep_rs1(3'b010);
        #1 chk("lu_stall", stall_IF_ID, 1);
        tick();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_rwe", reg_write_en_EX, 0);
        chk("lu_bub_alu", alu_op_EX, 0);
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_stall_after", stall_IF_ID, 0);
        tick();
        chk("lu_cap_valid", ex_valid, 1);
        chk("lu_cap_rs1", rd_sel1_in, 3'b010);
        chk("lu_cap_wsel", write_sel_EX, 3'b011);
        chk("lu_cap_d1", ex_rd_data1, 10'h0AB);
        chk("lu_cap_cnt", bubble_cnt, 1);

        // Immediate suppresses the rs2 match
        load_into_ex(3'b010, 10'h111);
        clear_id();
        id_valid = 1; id_rd_sel1 = 3'b010; id_rd_sel2 = 3'b010; id_uses_rs2 = 1;
        id_imm_sel = 1; id_imm = 10'h03F; id_write_sel = 3'b100; id_reg_write_en = 1;
        #1 chk("imm_stall", stall_IF_ID, 0);
        tick();
        chk("imm_valid", ex_valid, 1);
        chk("imm_sel", imm_sel, 1);
        chk("imm_val", ex_imm, 10'h03F);
        chk("imm_cnt", bubble_cnt, 1);

        // ext_stall over hazard for 3 cycles: frozen
        load_into_ex(3'b010, 10'h155);
        dep_rs1(3'b010);
        ext_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", stall_IF_ID, 1);
            tick();
            chk("hold_valid", ex_valid, 1);
            chk("hold_d1", ex_rd_data1, 10'h155);
            chk("hold_wsel", write_sel_EX, 3'b010);
            chk("hold_cnt", bubble_cnt, 1);
        end
        flush = 1;
        #1 chk("fl_es_stall", stall_IF_ID, 1);
        tick();
        chk("fl_es_valid", ex_valid, 0);
        chk("fl_es_rwe", reg_write_en_EX, 0);
        chk("fl_es_cnt", bubble_cnt, 1);
        flush = 0; ext_stall = 0;

        // Flush with hazard, no ext_stall: bubble, no count, no stall
        load_into_ex(3'b010, 10'h155);
        dep_rs1(3'b010);
        flush = 1;
        #1 chk("fl_hz_stall", stall_IF_ID, 0);
        tick();
        chk("fl_hz_valid", ex_valid, 0);
        chk("fl_hz_cnt", bubble_cnt, 1);
        flush = 0;

        // id_valid=0 with matching selects: no hazard, bubble, no count
        load_into_ex(3'b010, 10'h155);
        dep_rs1(3'b010);
        id_valid = 0;
        #1 chk("nv_stall", stall_IF_ID, 0);
        tick();
        chk("nv_valid", ex_valid, 0);
        chk("nv_rwe", reg_write_en_EX, 0);
        chk("nv_cnt", bubble_cnt, 1);

        // r0 is matched like any other register
        load_into_ex(3'b000, 10'h001);
        dep_rs1(3'b000);
        #1 chk("r0_stall", stall_IF_ID, 1);
        tick();
        chk("r0_cnt", bubble_cnt, 2);
        chk("r0_valid", ex_valid, 0);

        // Saturation: self-dependent load alternates capture/bubble; 260 more bubbles
        clear_id();
        id_valid = 1; id_rd_sel1 = 3'b010; id_uses_rs1 = 1; id_write_sel = 3'b010;
        id_reg_write_en = 1; id_MemtoReg = 1;
        for (int i = 0; i < 260; i++) begin
            tick();
            tick();
            if (i == 251) chk("sat_254", bubble_cnt, 254);
        end
        chk("sat_255", bubble_cnt, 255);
        chk("sat_valid", ex_valid, 0);
        tick();
        tick();
        chk("sat_hold", bubble_cnt, 255);

        // Mid-operation reset discards pending hazard/stall
        load_into_ex(3'b010, 10'h155);
        dep_rs1(3'b010);
        ext_stall = 1; rst = 1;
        tick();
        chk("mr_cnt", bubble_cnt, 0);
        chk("mr_valid", ex_valid, 0);
        rst = 0; ext_stall = 0;
        #1 chk("mr_stall", stall_IF_ID, 0);
        tick();
        chk("mr_cap_valid", ex_valid, 1);
        chk("mr_cap_wsel", write_sel_EX, 3'b011);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
